// File: rtl/ysyx_220066_mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_220066_mem_stage_pkg
// Shared definitions for the MEM pipeline stage:
//   - memop_e : funct3 codes of load/store width and signedness
//   - state_e : access FSM state encoding
//   - misaligned_f / wmask_f : address-offset helpers used on the store side
// ---------------------------------------------------------------------------
package ysyx_220066_mem_stage_pkg;

  typedef enum logic [2:0] {
    MEMOP_B  = 3'b000,
    MEMOP_H  = 3'b001,
    MEMOP_W  = 3'b010,
    MEMOP_D  = 3'b011,
    MEMOP_BU = 3'b100,
    MEMOP_HU = 3'b101,
    MEMOP_WU = 3'b110
  } memop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned_f(input logic [2:0] op, input logic [2:0] off);
    logic mis;
    case (op)
      MEMOP_H, MEMOP_HU: mis = off[0];
      MEMOP_W, MEMOP_WU: mis = |off[1:0];
      MEMOP_D:           mis = |off;
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte enables for the access, shifted to the addressed lane.
  function automatic logic [7:0] wmask_f(input logic [2:0] op, input logic [2:0] off);
    logic [7:0] m;
    case (op)
      MEMOP_B, MEMOP_BU: m = 8'h01 << off;
      MEMOP_H, MEMOP_HU: m = 8'h03 << off;
      MEMOP_W, MEMOP_WU: m = 8'h0F << off;
      default:           m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ysyx_220066_mem_stage_if.sv
// ---------------------------------------------------------------------------
// ysyx_220066_mem_stage_if
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 store, 0 load
//   mem_addr  : doubleword-aligned address
//   mem_wdata : store data placed on its byte lane
//   mem_wmask : byte enables
//   mem_rdata : read data, valid only in the mem_ack cycle
//   mem_ack   : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface ysyx_220066_mem_stage_if #(
  parameter int ADDR_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wmask;
  logic [63:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/ysyx_220066_mem_stage_load_ext.sv
// ---------------------------------------------------------------------------
// ysyx_220066_load_ext
// Combinational load formatter: picks the addressed lane out of the 64-bit
// read word and sign- or zero-extends it according to the funct3 code.
//   rdata : raw doubleword from memory
//   off   : byte offset (address[2:0])
//   memop : funct3 code
//   data  : extended result for writeback
// ---------------------------------------------------------------------------
module ysyx_220066_load_ext
  import ysyx_220066_mem_stage_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  memop,
  output logic [63:0] data
);

  logic [63:0] lane_s;

  // Shift the addressed byte lane down to bit 0, then extend.
  always_comb begin
    lane_s = rdata >> {off, 3'b000};
    case (memop)
      MEMOP_B:  data = {{56{lane_s[7]}},  lane_s[7:0]};
      MEMOP_H:  data = {{48{lane_s[15]}}, lane_s[15:0]};
      MEMOP_W:  data = {{32{lane_s[31]}}, lane_s[31:0]};
      MEMOP_BU: data = {56'd0, lane_s[7:0]};
      MEMOP_HU: data = {48'd0, lane_s[15:0]};
      MEMOP_WU: data = {32'd0, lane_s[31:0]};
      MEMOP_D:  data = rdata;
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_220066_mem_stage.sv
// ---------------------------------------------------------------------------
// ysyx_220066_mem_stage
// MEM pipeline stage. Latches EX results, performs at most one data-memory
// access per instruction over the req/ack bus, and hands writeback info to WB.
//   clk, rst       : clock; synchronous active-low reset
//   block          : downstream hold (stage register frozen)
//   *_in           : EX results and pass-through tags
//   mem            : data-memory bus (master side)
//   stall          : access outstanding, upstream must hold
//   valid          : WB may consume this cycle
//   error          : upstream error or misaligned access
//   rd/RegWr/wb_data, csr/ecall/mret/done/csr_addr : writeback + tags
// ---------------------------------------------------------------------------
module ysyx_220066_mem_stage
  import ysyx_220066_mem_stage_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter bit ALIGN_CHK = 1'b1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        block,
  input  logic        valid_in,
  input  logic        error_in,
  input  logic [63:0] result_in,
  input  logic [63:0] wdata_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  MemOp_in,
  input  logic        MemRd_in,
  input  logic        MemWr_in,
  input  logic        RegWr_in,
  input  logic        csr_in,
  input  logic        ecall_in,
  input  logic        mret_in,
  input  logic        done_in,
  input  logic [11:0] csr_addr_in,
  ysyx_220066_mem_stage_if.master mem,
  output logic        stall,
  output logic        valid,
  output logic        error,
  output logic [4:0]  rd,
  output logic        RegWr,
  output logic [63:0] wb_data,
  output logic        csr,
  output logic        ecall,
  output logic        mret,
  output logic        done,
  output logic [11:0] csr_addr
);

  state_e      state_r;
  logic        valid_r, error_r, misal_r, memrd_r, memwr_r, regwr_r;
  logic        csr_r, ecall_r, mret_r, done_r;
  logic [63:0] result_r, wdata_r, rdata_r;
  logic [4:0]  rd_r;
  logic [2:0]  memop_r;
  logic [11:0] csr_addr_r;

  logic        stall_s, load_s, misal_s;
  state_e      next_s;
  logic [5:0]  wshift_s;
  logic [63:0] ext_s;

  // Alignment check of the incoming instruction; only memory ops can fault.
  always_comb begin
    if (ALIGN_CHK && (MemRd_in || MemWr_in)) begin
      misal_s = misaligned_f(MemOp_in, result_in[2:0]);
    end else begin
      misal_s = 1'b0;
    end
  end

  // State entered when a new instruction is captured.
  always_comb begin
    if (valid_in && (MemRd_in || MemWr_in) && !misal_s) begin
      next_s = S_REQ;
    end else begin
      next_s = S_IDLE;
    end
  end

  // Store data lane shift; a doubleword always occupies the full word.
  always_comb begin
    if (memop_r == MEMOP_D) begin
      wshift_s = 6'd0;
    end else begin
      wshift_s = {result_r[2:0], 3'b000};
    end
  end

  assign stall_s = valid_r && (state_r == S_REQ);
  assign load_s  = !block && !stall_s;

  // Stage register and access FSM: capture on load, complete on ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      valid_r    <= 1'b0;
      error_r    <= 1'b0;
      misal_r    <= 1'b0;
      memrd_r    <= 1'b0;
      memwr_r    <= 1'b0;
      regwr_r    <= 1'b0;
      csr_r      <= 1'b0;
      ecall_r    <= 1'b0;
      mret_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= 64'd0;
      wdata_r    <= 64'd0;
      rdata_r    <= 64'd0;
      rd_r       <= 5'd0;
      memop_r    <= 3'd0;
      csr_addr_r <= 12'd0;
    end else if (load_s) begin
      state_r    <= next_s;
      valid_r    <= valid_in;
      error_r    <= error_in;
      misal_r    <= misal_s;
      memrd_r    <= MemRd_in;
      memwr_r    <= MemWr_in;
      regwr_r    <= RegWr_in;
      csr_r      <= csr_in;
      ecall_r    <= ecall_in;
      mret_r     <= mret_in;
      done_r     <= done_in;
      result_r   <= result_in;
      wdata_r    <= wdata_in;
      rd_r       <= rd_in;
      memop_r    <= MemOp_in;
      csr_addr_r <= csr_addr_in;
    end else if (stall_s && mem.mem_ack) begin
      // rdata is only valid in the ack cycle, so it is captured here.
      state_r <= S_DONE;
      rdata_r <= mem.mem_rdata;
    end
  end

  ysyx_220066_load_ext u_load_ext (
    .rdata (rdata_r),
    .off   (result_r[2:0]),
    .memop (memop_r),
    .data  (ext_s)
  );

  assign mem.mem_req   = stall_s;
  assign mem.mem_we    = memwr_r;
  assign mem.mem_addr  = {result_r[ADDR_W-1:3], 3'b000};
  assign mem.mem_wdata = wdata_r << wshift_s;
  assign mem.mem_wmask = wmask_f(memop_r, result_r[2:0]);

  assign stall    = stall_s;
  assign valid    = valid_r && (state_r != S_REQ);
  assign error    = error_r | misal_r;
  assign rd       = rd_r;
  assign RegWr    = regwr_r & ~misal_r;
  assign wb_data  = (memrd_r && !misal_r) ? ext_s : result_r;
  assign csr      = csr_r;
  assign ecall    = ecall_r;
  assign mret     = mret_r;
  assign done     = done_r;
  assign csr_addr = csr_addr_r;

endmodule

// File: tb/tb_ysyx_220066_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ysyx_220066_mem_stage
// Self-checking bench for the MEM stage: directed scenarios followed by
// randomized loads/stores/ALU ops checked against a byte-level reference
// model. Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ysyx_220066_mem_stage;

  logic        clk = 1'b0;
  logic        rst, block, valid_in, error_in;
  logic [63:0] result_in, wdata_in;
  logic [4:0]  rd_in;
  logic [2:0]  MemOp_in;
  logic        MemRd_in, MemWr_in, RegWr_in, csr_in, ecall_in, mret_in, done_in;
  logic [11:0] csr_addr_in;
  logic        stall, valid, error, RegWr, csr, ecall, mret, done;
  logic [4:0]  rd;
  logic [63:0] wb_data;
  logic [11:0] csr_addr;

  int n_vec = 0;
  int n_err = 0;

  ysyx_220066_mem_stage_if #(.ADDR_W(64)) bus ();

  ysyx_220066_mem_stage #(.ADDR_W(64), .ALIGN_CHK(1'b1)) dut (
    .clk(clk), .rst(rst), .block(block), .valid_in(valid_in), .error_in(error_in),
    .result_in(result_in), .wdata_in(wdata_in), .rd_in(rd_in), .MemOp_in(MemOp_in),
    .MemRd_in(MemRd_in), .MemWr_in(MemWr_in), .RegWr_in(RegWr_in), .csr_in(csr_in),
    .ecall_in(ecall_in), .mret_in(mret_in), .done_in(done_in), .csr_addr_in(csr_addr_in),
    .mem(bus), .stall(stall), .valid(valid), .error(error), .rd(rd), .RegWr(RegWr),
    .wb_data(wb_data), .csr(csr), .ecall(ecall), .mret(mret), .done(done), .csr_addr(csr_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model (byte-level arithmetic) ----
  function automatic int unsigned size_of(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010, 3'b110: return 4;
      default:        return 8;
    endcase
  endfunction

  function automatic logic misal_of(input logic [2:0] op, input int unsigned off);
    return (off % size_of(op)) != 0;
  endfunction

  function automatic logic [7:0] mask_of(input logic [2:0] op, input int unsigned off);
    logic [7:0] m = 8'h00;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + size_of(op)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] wdata_of(input logic [2:0] op, input int unsigned off,
                                           input logic [63:0] wd);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + size_of(op)) r[8*i +: 8] = wd[8*(i-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ext_of(input logic [2:0] op, input int unsigned off,
                                         input logic [63:0] rdat);
    logic [63:0] v = 64'd0;
    int unsigned sz = size_of(op);
    for (int j = 0; j < sz; j++) v[8*j +: 8] = rdat[8*(off+j) +: 8];
    if (op < 3'd3 && v[8*sz-1])
      for (int k = 8*sz; k < 64; k++) v[k] = 1'b1;
    return v;
  endfunction

  // One instruction through the stage, ack after `delay` request cycles.
  task automatic run_op(input string nm, input logic mrd, input logic mwr, input logic [2:0] op,
                        input logic [63:0] addr, input logic [63:0] wd, input logic rw,
                        input logic ein, input logic [63:0] rdat, input int delay);
    logic [4:0]  rdi = 5'($urandom);
    logic        ec  = 1'($urandom);
    logic [11:0] ca  = 12'($urandom);
    int unsigned off = int'(addr[2:0]);
    logic mis = (mrd | mwr) && misal_of(op, off);
    logic req = (mrd | mwr) && !mis;
    @(negedge clk);
    valid_in = 1'b1; MemRd_in = mrd; MemWr_in = mwr; MemOp_in = op; result_in = addr;
    wdata_in = wd; RegWr_in = rw; error_in = ein; rd_in = rdi; ecall_in = ec; csr_addr_in = ca;
    @(negedge clk);
    valid_in = 1'b0; MemRd_in = 1'b0; MemWr_in = 1'b0;
    if (req) begin
      check({nm, ":addr"}, bus.mem_addr, {addr[63:3], 3'b000});
      check({nm, ":we"}, bus.mem_we, mwr);
      check({nm, ":wmask"}, bus.mem_wmask, mask_of(op, off));
      if (mwr) check({nm, ":wdata"}, bus.mem_wdata, wdata_of(op, off, wd));
      for (int k = 1; k <= delay; k++) begin
        check({nm, ":stall"}, stall, 1'b1);
        check({nm, ":req"}, bus.mem_req, 1'b1);
        check({nm, ":valid_lo"}, valid, 1'b0);
        if (k == delay) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = rdat;
        end else begin
          bus.mem_ack = 1'b0; bus.mem_rdata = {$urandom, $urandom};
        end
        @(negedge clk);
      end
      bus.mem_ack = 1'b0; bus.mem_rdata = {$urandom, $urandom};
    end
    check({nm, ":valid"}, valid, 1'b1);
    check({nm, ":stall0"}, stall, 1'b0);
    check({nm, ":req0"}, bus.mem_req, 1'b0);
    check({nm, ":error"}, error, ein | mis);
    check({nm, ":RegWr"}, RegWr, rw & ~mis);
    check({nm, ":wb"}, wb_data, (mrd && !mis) ? ext_of(op, off, rdat) : addr);
    check({nm, ":rd"}, rd, rdi);
    check({nm, ":ecall"}, ecall, ec);
    check({nm, ":csr_addr"}, csr_addr, ca);
  endtask

  logic [63:0] exp_wb;

  initial begin
    rst = 1'b0; block = 1'b0; valid_in = 1'b0; error_in = 1'b0; result_in = 64'd0;
    wdata_in = 64'd0; rd_in = 5'd0; MemOp_in = 3'd0; MemRd_in = 1'b0; MemWr_in = 1'b0;
    RegWr_in = 1'b0; csr_in = 1'b0; ecall_in = 1'b0; mret_in = 1'b0; done_in = 1'b0;
    csr_addr_in = 12'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 64'd0;
    repeat (2) @(negedge clk);
    check("rst:valid", valid, 1'b0);
    check("rst:stall", stall, 1'b0);
    check("rst:req", bus.mem_req, 1'b0);
    check("rst:wb", wb_data, 64'd0);
    rst = 1'b1;

    // Directed scenarios.
    run_op("alu", 1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 1'b1, 1'b0, 64'd0, 0);
    run_op("lb", 1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_1003, 64'd0, 1'b1, 1'b0,
           64'h0000_0000_8000_0000, 3);
    check("lb:literal", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    run_op("sh", 1'b0, 1'b1, 3'b001, 64'h0000_0000_8000_2006, 64'hBEEF, 1'b0, 1'b0, 64'd0, 2);
    run_op("lw_mis", 1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0002, 64'd0, 1'b1, 1'b0, 64'd0, 0);
    run_op("ld", 1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0010, 64'd0, 1'b1, 1'b1,
           64'h8123_4567_89AB_CDEF, 1);

    // lwu completing under block: result held until block drops.
    @(negedge clk);
    valid_in = 1'b1; MemRd_in = 1'b1; MemOp_in = 3'b110; result_in = 64'h3004;
    RegWr_in = 1'b1; rd_in = 5'd7; error_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0; MemRd_in = 1'b0; block = 1'b1;
    check("blk:req", bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'h8765_4321_DEAD_BEEF;
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.mem_rdata = 64'd0;
    exp_wb = ext_of(3'b110, 4, 64'h8765_4321_DEAD_BEEF);
    valid_in = 1'b1; MemOp_in = 3'b000; result_in = 64'hCAFE; rd_in = 5'd9;
    for (int i = 0; i < 3; i++) begin
      check("blk:valid", valid, 1'b1);
      check("blk:wb", wb_data, exp_wb);
      check("blk:rd", rd, 5'd7);
      @(negedge clk);
    end
    block = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    check("blk:next_valid", valid, 1'b1);
    check("blk:next_wb", wb_data, 64'hCAFE);
    check("blk:next_rd", rd, 5'd9);

    // Reset in the middle of an access; a late ack must be ignored.
    @(negedge clk);
    valid_in = 1'b1; MemRd_in = 1'b1; MemOp_in = 3'b000; result_in = 64'h40; RegWr_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; MemRd_in = 1'b0;
    check("rreq:req", bus.mem_req, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("rreq:req0", bus.mem_req, 1'b0);
    check("rreq:valid0", valid, 1'b0);
    check("rreq:stall0", stall, 1'b0);
    check("rreq:wb0", wb_data, 64'd0);
    rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("late:req", bus.mem_req, 1'b0);
    check("late:valid", valid, 1'b0);
    check("late:stall", stall, 1'b0);

    // Randomized mix of ALU ops, loads and stores.
    for (int n = 0; n < 60; n++) begin
      int unsigned kind = $urandom_range(0, 2);
      logic [2:0]  op   = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      logic [63:0] a    = {$urandom, $urandom};
      int unsigned sz   = size_of(op);
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'(($urandom_range(0, 7) / sz) * sz);
      run_op("rnd", kind == 1, kind == 2, op, a, {$urandom, $urandom}, kind != 2,
             1'($urandom_range(0, 5) == 0), {$urandom, $urandom}, int'($urandom_range(1, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
